// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: sequential word fetches over the imem handshake,
// a 2-entry decode queue of {instr, pc}, and branch redirect with flush.
module imem_fetch_ctrl #(
  parameter int                   PC_WIDTH    = 16,
  parameter int                   INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = 16'h3000,
  parameter int                   QDEPTH      = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic [PC_WIDTH-1:0]    PC,
  output logic                   instrmem_rd,
  input  logic [INSTR_WIDTH-1:0] Instr_dout,
  input  logic                   complete_instr,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   dec_valid,
  output logic [INSTR_WIDTH-1:0] dec_instr,
  output logic [PC_WIDTH-1:0]    dec_pc,
  input  logic                   dec_ready
);

  typedef enum logic [1:0] {REDIR, FETCH, HOLD} state_t;

  localparam logic [1:0] FULL = 2'(QDEPTH);

  state_t                 state;
  logic [1:0]             count;
  logic [1:0]             count_nxt;
  logic                   push;
  logic                   pop;
  logic [INSTR_WIDTH-1:0] q_instr_p0, q_instr_p1;
  logic [PC_WIDTH-1:0]    q_pc_p0, q_pc_p1;

  // Redirect and reset suppress both queue operations; the flush wins.
  always_comb begin
    push      = reset && !redirect_valid && (state == FETCH) && complete_instr;
    pop       = reset && !redirect_valid && dec_valid && dec_ready;
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= REDIR;
      PC          <= RESET_PC;
      instrmem_rd <= 1'b0;
      count       <= 2'd0;
    end else if (redirect_valid) begin
      state       <= REDIR;
      PC          <= redirect_pc;
      instrmem_rd <= 1'b0;
      count       <= 2'd0;
    end else begin
      count <= count_nxt;
      case (state)
        REDIR: begin
          state       <= FETCH;
          instrmem_rd <= 1'b1;
        end
        FETCH: begin
          if (push) begin
            PC <= PC + PC_WIDTH'(1);
            if (count_nxt == FULL) begin
              state       <= HOLD;
              instrmem_rd <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (count_nxt != FULL) begin
            state       <= FETCH;
            instrmem_rd <= 1'b1;
          end
        end
        default: begin
          state       <= REDIR;
          instrmem_rd <= 1'b0;
        end
      endcase
    end
  end

  // Head entry: loads when the new word lands at the front, else shifts up on pop.
  always_ff @(posedge clock) begin
    if (!reset) begin
      q_instr_p0 <= '0;
      q_pc_p0    <= '0;
    end else if (push && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
      q_instr_p0 <= Instr_dout;
      q_pc_p0    <= PC;
    end else if (pop && (count == FULL)) begin
      q_instr_p0 <= q_instr_p1;
      q_pc_p0    <= q_pc_p1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && (count == 2'd1) && !pop) begin
      q_instr_p1 <= Instr_dout;
      q_pc_p1    <= PC;
    end
  end

  assign dec_valid = (count != 2'd0);
  assign dec_instr = q_instr_p0;
  assign dec_pc    = q_pc_p0;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl; memory model returns PC ^ 16'hA5A5.
module tb_imem_fetch_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] PC;
  logic        instrmem_rd;
  logic [15:0] Instr_dout;
  logic        complete_instr;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        dec_valid;
  logic [15:0] dec_instr;
  logic [15:0] dec_pc;
  logic        dec_ready;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clock = ~clock;

  assign Instr_dout = PC ^ 16'hA5A5;

  imem_fetch_ctrl #(
    .PC_WIDTH(16), .INSTR_WIDTH(16), .RESET_PC(16'h3000), .QDEPTH(2)
  ) dut (
    .clock(clock), .reset(reset), .PC(PC), .instrmem_rd(instrmem_rd),
    .Instr_dout(Instr_dout), .complete_instr(complete_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_ready(dec_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset          = 1'b0;
    complete_instr = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    dec_ready      = 1'b0;

    // Reset values
    step();
    step();
    chk("rst_pc", PC, 16'h3000);
    chk("rst_rd", instrmem_rd, 1'b0);
    chk("rst_dv", dec_valid, 1'b0);
    chk("rst_di", dec_instr, 16'h0000);
    chk("rst_dp", dec_pc, 16'h0000);

    // Zero-wait memory, decode always ready
    reset = 1'b1; complete_instr = 1'b1; dec_ready = 1'b1;
    step();
    chk("zw_rd0", instrmem_rd, 1'b1);
    chk("zw_pc0", PC, 16'h3000);
    chk("zw_dv0", dec_valid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("zw_dv", dec_valid, 1'b1);
      chk("zw_dp", dec_pc, 16'h3000 + 16'(i));
      chk("zw_di", dec_instr, (16'h3000 + 16'(i)) ^ 16'hA5A5);
      chk("zw_pc", PC, 16'h3001 + 16'(i));
    end

    // 3-cycle wait memory
    do_reset();
    complete_instr = 1'b0; dec_ready = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      complete_instr = 1'b0;
      step();
      chk("w3_pca", PC, 16'h3000 + 16'(k));
      chk("w3_rda", instrmem_rd, 1'b1);
      chk("w3_dva", dec_valid, 1'b0);
      step();
      chk("w3_pcb", PC, 16'h3000 + 16'(k));
      chk("w3_dvb", dec_valid, 1'b0);
      complete_instr = 1'b1;
      step();
      chk("w3_dvc", dec_valid, 1'b1);
      chk("w3_dpc", dec_pc, 16'h3000 + 16'(k));
      chk("w3_pcc", PC, 16'h3001 + 16'(k));
    end

    // Back-pressure: fill queue, HOLD, single pop, refetch
    do_reset();
    complete_instr = 1'b1; dec_ready = 1'b0;
    step();
    step();
    chk("bp_dp1", dec_pc, 16'h3000);
    step();
    chk("bp_rd_hold", instrmem_rd, 1'b0);
    chk("bp_pc_hold", PC, 16'h3002);
    chk("bp_dp_hold", dec_pc, 16'h3000);
    step();
    chk("bp_pc_ign", PC, 16'h3002);
    chk("bp_rd_ign", instrmem_rd, 1'b0);
    chk("bp_dv_ign", dec_valid, 1'b1);
    dec_ready = 1'b1; complete_instr = 1'b0;
    step();
    chk("bp_dp_pop", dec_pc, 16'h3001);
    chk("bp_di_pop", dec_instr, 16'h95A4);
    chk("bp_rd_pop", instrmem_rd, 1'b1);
    chk("bp_pc_pop", PC, 16'h3002);
    dec_ready = 1'b0; complete_instr = 1'b1;
    step();
    chk("bp_rd_full", instrmem_rd, 1'b0);
    chk("bp_pc_full", PC, 16'h3003);
    dec_ready = 1'b1; complete_instr = 1'b0;
    step();
    chk("bp_dp_2", dec_pc, 16'h3002);
    chk("bp_di_2", dec_instr, 16'h95A7);

    // Redirect coincident with completion of 3005
    do_reset();
    complete_instr = 1'b1; dec_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("rd_pre_pc", PC, 16'h3005);
    chk("rd_pre_dp", dec_pc, 16'h3004);
    redirect_valid = 1'b1; redirect_pc = 16'h4000;
    step();
    chk("rd_pc", PC, 16'h4000);
    chk("rd_rd", instrmem_rd, 1'b0);
    chk("rd_dv", dec_valid, 1'b0);
    redirect_valid = 1'b0;
    step();
    chk("rd_rd1", instrmem_rd, 1'b1);
    chk("rd_pc1", PC, 16'h4000);
    chk("rd_dv1", dec_valid, 1'b0);
    step();
    chk("rd_dp2", dec_pc, 16'h4000);
    chk("rd_di2", dec_instr, 16'hE5A5);
    chk("rd_pc2", PC, 16'h4001);

    // Redirect to FFFF, address wrap
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    step();
    chk("wr_pc", PC, 16'hFFFF);
    chk("wr_dv", dec_valid, 1'b0);
    redirect_valid = 1'b0;
    step();
    chk("wr_rd1", instrmem_rd, 1'b1);
    step();
    chk("wr_dp1", dec_pc, 16'hFFFF);
    chk("wr_di1", dec_instr, 16'h5A5A);
    chk("wr_pc1", PC, 16'h0000);
    step();
    chk("wr_dp2", dec_pc, 16'h0000);
    chk("wr_di2", dec_instr, 16'hA5A5);
    chk("wr_pc2", PC, 16'h0001);

    // Reset with a full queue
    do_reset();
    complete_instr = 1'b1; dec_ready = 1'b0;
    step();
    step();
    step();
    chk("mr_full_rd", instrmem_rd, 1'b0);
    reset = 1'b0;
    step();
    chk("mr_pc", PC, 16'h3000);
    chk("mr_rd", instrmem_rd, 1'b0);
    chk("mr_dv", dec_valid, 1'b0);
    chk("mr_di", dec_instr, 16'h0000);
    chk("mr_dp", dec_pc, 16'h0000);
    reset = 1'b1; dec_ready = 1'b1;
    step();
    chk("mr_rd1", instrmem_rd, 1'b1);
    chk("mr_pc1", PC, 16'h3000);
    step();
    chk("mr_dp2", dec_pc, 16'h3000);
    chk("mr_di2", dec_instr, 16'h95A5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
